multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/inst_decoder.sv | 100 ++++++++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control: FSM states, opcode[6:2] values,
// writeback, ALU and immediate select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StMem     = 3'd4,
    StMduWait = 3'd5,
    StWb      = 3'd6,
    StHalt    = 3'd7
  } ctrl_state_e;

  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpReg    = 5'b01100;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpJal    = 5'b11011;

  localparam logic [1:0] WbMem = 2'b00;
  localparam logic [1:0] WbAlu = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluLui = 5'b01001;

  // One-hot {J,U,B,S,I}
  localparam logic [4:0] ImmNone = 5'b00000;
  localparam logic [4:0] ImmI    = 5'b00001;
  localparam logic [4:0] ImmS    = 5'b00010;
  localparam logic [4:0] ImmB    = 5'b00100;
  localparam logic [4:0] ImmU    = 5'b01000;
  localparam logic [4:0] ImmJ    = 5'b10000;

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I(M) decode: legality, instruction class and datapath selects.
module inst_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned M_EXT = 0
) (
  input  logic [31:0] inst_i,
  output logic        legal_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_branch_o,
  output logic        is_jump_o,
  output logic        is_mtype_o,
  output logic [4:0]  imm_sel_o,
  output logic [4:0]  alu_sel_o,
  output logic        a_sel_o,
  output logic        b_sel_o,
  output logic        br_un_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  ld_st_sel_o
);

  localparam logic MExt = (M_EXT != 0);

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       m_bit;
  logic       unused_inst;

  assign opcode      = inst_i[6:2];
  assign funct3      = inst_i[14:12];
  assign m_bit       = inst_i[25];
  assign ld_st_sel_o = funct3;
  assign unused_inst = ^{inst_i[31], inst_i[29:26], inst_i[24:15], inst_i[11:7]};

  always_comb begin
    legal_o     = 1'b1;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    is_jump_o   = 1'b0;
    is_mtype_o  = 1'b0;
    imm_sel_o   = ImmNone;
    alu_sel_o   = AluAdd;
    a_sel_o     = 1'b0;
    b_sel_o     = 1'b1;
    br_un_o     = 1'b0;
    wb_sel_o    = WbAlu;
    case (opcode)
      OpLoad: begin
        is_load_o = 1'b1;
        imm_sel_o = ImmI;
        wb_sel_o  = WbMem;
      end
      OpImm: begin
        imm_sel_o = ImmI;
        // inst[30] only distinguishes SRAI from SRLI; elsewhere it is immediate data
        alu_sel_o = {1'b0, (funct3 == 3'b101) & inst_i[30], funct3};
      end
      OpAuipc: begin
        imm_sel_o = ImmU;
        a_sel_o   = 1'b1;
      end
      OpStore: begin
        is_store_o = 1'b1;
        imm_sel_o  = ImmS;
      end
      OpReg: begin
        b_sel_o    = 1'b0;
        is_mtype_o = m_bit & MExt;
        alu_sel_o  = {m_bit & MExt, inst_i[30], funct3};
        if (m_bit && !MExt) legal_o = 1'b0;
      end
      OpLui: begin
        imm_sel_o = ImmU;
        alu_sel_o = AluLui;
      end
      OpBranch: begin
        is_branch_o = 1'b1;
        imm_sel_o   = ImmB;
        a_sel_o     = 1'b1;
        br_un_o     = funct3[1];
      end
      OpJalr: begin
        is_jump_o = 1'b1;
        imm_sel_o = ImmI;
        wb_sel_o  = WbPc4;
      end
      OpJal: begin
        is_jump_o = 1'b1;
        imm_sel_o = ImmJ;
        a_sel_o   = 1'b1;
        wb_sel_o  = WbPc4;
      end
      default: legal_o = 1'b0;
    endcase
    if (inst_i[1:0] != 2'b11) legal_o = 1'b0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I(M) control FSM: fetch/decode/execute/memory/MDU/writeback sequencing
// around an external IR, with combinational datapath selects from the decoder.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned M_EXT           = 0,
  parameter int unsigned HALT_ON_ILLEGAL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        imem_rdy_i,
  input  logic        dmem_rdy_i,
  input  logic        BrEq,
  input  logic        BrLT,
  input  logic        mdu_done_i,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic [4:0]  imm_sel_o,
  output logic [4:0]  alu_sel_o,
  output logic        a_sel_o,
  output logic        b_sel_o,
  output logic        BrUn_o,
  output logic        dmem_req_o,
  output logic        memRW_o,
  output logic [2:0]  ld_st_sel_o,
  output logic [1:0]  wb_sel_o,
  output logic        regWEn_o,
  output logic        mdu_start_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  ctrl_state_e state_q, state_d;
  logic        illegal_q, illegal_d;

  logic       dec_legal, dec_load, dec_store, dec_branch, dec_jump, dec_mtype;
  logic [4:0] dec_imm_sel, dec_alu_sel;
  logic       dec_a_sel, dec_b_sel, dec_br_un;
  logic [1:0] dec_wb_sel;
  logic [2:0] dec_funct3;
  logic       br_taken;
  logic       in_idle;

  inst_decoder #(
    .M_EXT(M_EXT)
  ) u_inst_decoder (
    .inst_i      (inst_i),
    .legal_o     (dec_legal),
    .is_load_o   (dec_load),
    .is_store_o  (dec_store),
    .is_branch_o (dec_branch),
    .is_jump_o   (dec_jump),
    .is_mtype_o  (dec_mtype),
    .imm_sel_o   (dec_imm_sel),
    .alu_sel_o   (dec_alu_sel),
    .a_sel_o     (dec_a_sel),
    .b_sel_o     (dec_b_sel),
    .br_un_o     (dec_br_un),
    .wb_sel_o    (dec_wb_sel),
    .ld_st_sel_o (dec_funct3)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    unique case (dec_funct3)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = ~BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = ~BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    dmem_req_o  = 1'b0;
    memRW_o     = 1'b0;
    regWEn_o    = 1'b0;
    mdu_start_o = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_rdy_i) begin
          ir_we_o = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          if (HALT_ON_ILLEGAL != 0) begin
            state_d = StHalt;
          end else begin
            // Retire as a NOP: step PC to PC+4 and refetch
            pc_we_o = 1'b1;
            state_d = StFetch;
          end
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_branch) begin
          pc_sel_o = br_taken;
          pc_we_o  = 1'b1;
          state_d  = StFetch;
        end else if (dec_load || dec_store) begin
          state_d = StMem;
        end else if (dec_mtype) begin
          mdu_start_o = 1'b1;
          state_d     = StMduWait;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req_o = 1'b1;
        memRW_o    = dec_store;
        if (dmem_rdy_i) begin
          if (dec_store) begin
            pc_we_o = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StMduWait: if (mdu_done_i) state_d = StWb;
      StWb: begin
        regWEn_o = 1'b1;
        pc_we_o  = 1'b1;
        pc_sel_o = dec_jump;
        state_d  = StFetch;
      end
      StHalt: state_d = StHalt;
    endcase
  end

  // Datapath selects are forced to zero in IDLE so reset leaves every output quiet
  assign in_idle     = (state_q == StIdle);
  assign imm_sel_o   = in_idle ? 5'b0 : dec_imm_sel;
  assign alu_sel_o   = in_idle ? 5'b0 : dec_alu_sel;
  assign a_sel_o     = ~in_idle & dec_a_sel;
  assign b_sel_o     = ~in_idle & dec_b_sel;
  assign BrUn_o      = ~in_idle & dec_br_un;
  assign wb_sel_o    = in_idle ? 2'b0 : dec_wb_sel;
  assign ld_st_sel_o = in_idle ? 3'b0 : dec_funct3;
  assign illegal_o   = illegal_q;
  assign state_o     = state_q;

endmodule
